// File: rtl/irq_controller.sv
// irq_controller
//   Round-robin interrupt controller in front of the core. Each cycle in SCAN
//   one source (the one under ptr) is examined. An enabled request is latched
//   into PEND, which raises int_o and presents a RISC-V mcause value. The
//   core's end-of-service pulse moves the block into a one-cycle ACK state. ACK
//   pulses the one-hot acknowledge back to the serviced peripheral and then
//   advances ptr past it.
//
// Ports
//   clk_i      system clock, posedge
//   arstn_i    synchronous active-low reset
//   irq_i      level peripheral requests, held until acknowledged
//   mie_i      core mie CSR; bit 16+k enables source k
//   int_rst_i  one-cycle end-of-service pulse from the core (mret)
//   int_o      interrupt request to the core
//   mcause_o   cause of the pending interrupt (valid while int_o=1)
//   irq_ret_o  one-hot acknowledge to the serviced peripheral
module irq_controller #(
    parameter int NUM_IRQ = 16,
    parameter int CNT_W   = 4
) (
    input  logic               clk_i,
    input  logic               arstn_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [31:0]        mie_i,
    input  logic               int_rst_i,
    output logic               int_o,
    output logic [31:0]        mcause_o,
    output logic [NUM_IRQ-1:0] irq_ret_o
);

    localparam int PAD = 1 << CNT_W;

    localparam logic [1:0] ST_SCAN = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [CNT_W-1:0] PTR_LAST = CNT_W'(NUM_IRQ - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] ptr;
    logic [CNT_W-1:0] ptr_inc;
    logic [PAD-1:0]   req_pad;
    logic             hit;

    // Only mie[16 +: NUM_IRQ] matters; the rest of the CSR is deliberately ignored.
    logic unused_mie;
    assign unused_mie = ^mie_i;

    // Masked requests, zero-padded to the full pointer range so ptr can index
    // the vector directly whatever NUM_IRQ is.
    always_comb begin
        req_pad                = '0;
        req_pad[NUM_IRQ-1:0]   = irq_i & mie_i[16 +: NUM_IRQ];
    end

    assign hit     = req_pad[ptr];
    assign ptr_inc = (ptr == PTR_LAST) ? '0 : ptr + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state    <= ST_SCAN;
            ptr      <= '0;
            mcause_o <= 32'h0;
        end else begin
            case (state)
                ST_SCAN: begin
                    if (hit) begin
                        state    <= ST_PEND;
                        mcause_o <= 32'h8000_0010 + 32'(ptr);
                    end else begin
                        ptr <= ptr_inc;
                    end
                end
                // Committed: the request cannot be withdrawn, only serviced.
                ST_PEND: begin
                    if (int_rst_i) state <= ST_ACK;
                end
                // Step past the serviced source so it gets lowest priority next.
                ST_ACK: begin
                    state <= ST_SCAN;
                    ptr   <= ptr_inc;
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

    assign int_o = (state == ST_PEND);

    // Per-source acknowledge decode.
    for (genvar k = 0; k < NUM_IRQ; k++) begin : g_ret
        assign irq_ret_o[k] = (state == ST_ACK) && (ptr == CNT_W'(k));
    end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    localparam int N = 16;

    logic          clk_i = 1'b0;
    logic          arstn_i;
    logic [N-1:0]  irq_i;
    logic [31:0]   mie_i;
    logic          int_rst_i;
    logic          int_o;
    logic [31:0]   mcause_o;
    logic [N-1:0]  irq_ret_o;

    int n_cmp = 0;
    int n_err = 0;

    irq_controller #(.NUM_IRQ(N), .CNT_W(4)) dut (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .irq_i     (irq_i),
        .mie_i     (mie_i),
        .int_rst_i (int_rst_i),
        .int_o     (int_o),
        .mcause_o  (mcause_o),
        .irq_ret_o (irq_ret_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model. It tracks which source is being serviced (or -1),
    // whether the acknowledge cycle is due, and the next source to examine.
    int          m_next  = 0;
    int          m_svc   = -1;
    bit          m_ackd  = 1'b0;
    logic [31:0] m_cause = 32'h0;

    task automatic model_step(input logic r, input logic [N-1:0] irq,
                              input logic [31:0] mie, input logic ir);
        if (!r) begin
            m_next = 0; m_svc = -1; m_ackd = 1'b0; m_cause = 32'h0;
        end else if (m_ackd) begin
            m_next = (m_svc + 1) % N; m_svc = -1; m_ackd = 1'b0;
        end else if (m_svc >= 0) begin
            if (ir) m_ackd = 1'b1;
        end else if (irq[m_next] && mie[16 + m_next]) begin
            m_svc   = m_next;
            m_cause = 32'h8000_0000 | (16 + m_next);
        end else begin
            m_next = (m_next + 1) % N;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive, clock edge, model update, compare at the falling edge.
    task automatic tick(input logic r, input logic [N-1:0] irq,
                        input logic [31:0] mie, input logic ir);
        logic [N-1:0] e_ret;
        arstn_i = r; irq_i = irq; mie_i = mie; int_rst_i = ir;
        @(posedge clk_i);
        model_step(r, irq, mie, ir);
        @(negedge clk_i);
        e_ret = '0;
        if (m_ackd) e_ret[m_svc] = 1'b1;
        chk("model_int",   32'(int_o),     32'(m_svc >= 0 && !m_ackd));
        chk("model_cause", mcause_o,       m_cause);
        chk("model_ret",   32'(irq_ret_o), 32'(e_ret));
    endtask

    // Hold a request until int_o rises, at most N cycles.
    task automatic wait_int(input string name, input logic [N-1:0] irq, input logic [31:0] mie);
        bit seen = 1'b0;
        for (int i = 0; i < N; i++) begin
            tick(1'b1, irq, mie, 1'b0);
            if (int_o) begin seen = 1'b1; break; end
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    typedef struct {
        logic          rst_n;
        logic [N-1:0]  irq;
        logic [31:0]   mie;
        logic          int_rst;
        logic          e_int;
        logic [31:0]   e_cause;
        logic [N-1:0]  e_ret;
    } vec_t;

    vec_t        tbl[18];
    int          svc_q[$];
    logic [N-1:0] pend;
    logic [31:0]  rmie;
    logic         rrst;

    initial begin
        arstn_i = 1'b0; irq_i = '0; mie_i = '0; int_rst_i = 1'b0;

        //            rst   irq       mie           ir    int   cause          ret
        tbl[0]  = '{1'b0, 16'hFFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         16'h0};
        tbl[1]  = '{1'b0, 16'hFFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         16'h0};
        tbl[2]  = '{1'b0, 16'hFFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         16'h0};
        tbl[3]  = '{1'b1, 16'hFFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0010, 16'h0};
        tbl[4]  = '{1'b1, 16'hFFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0010, 16'h0001};
        tbl[5]  = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0010, 16'h0};
        tbl[6]  = '{1'b1, 16'h0002, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0011, 16'h0};
        tbl[7]  = '{1'b1, 16'h0002, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0011, 16'h0};
        tbl[8]  = '{1'b1, 16'h0002, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0011, 16'h0002};
        tbl[9]  = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_0011, 16'h0};
        tbl[10] = '{1'b1, 16'h0004, 32'h0000_0000, 1'b0, 1'b0, 32'h8000_0011, 16'h0};
        tbl[11] = '{1'b1, 16'h0008, 32'h0008_0000, 1'b0, 1'b1, 32'h8000_0013, 16'h0};
        tbl[12] = '{1'b1, 16'h0000, 32'h0000_0000, 1'b0, 1'b1, 32'h8000_0013, 16'h0};
        tbl[13] = '{1'b0, 16'h0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         16'h0};
        tbl[14] = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,         16'h0};
        tbl[15] = '{1'b1, 16'h0002, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0011, 16'h0};
        tbl[16] = '{1'b1, 16'h0002, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0011, 16'h0002};
        tbl[17] = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_0011, 16'h0};

        // Directed table: reset, back-to-back service, masking, reset mid-PEND,
        // stray int_rst in SCAN.
        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].rst_n, tbl[i].irq, tbl[i].mie, tbl[i].int_rst);
            chk($sformatf("tbl%0d_int", i),   32'(int_o),     32'(tbl[i].e_int));
            chk($sformatf("tbl%0d_cause", i), mcause_o,       tbl[i].e_cause);
            chk($sformatf("tbl%0d_ret", i),   32'(irq_ret_o), 32'(tbl[i].e_ret));
        end

        // Single source 3.
        wait_int("single_latency", 16'h0008, 32'h0008_0000);
        chk("single_cause", mcause_o, 32'h8000_0013);
        tick(1'b1, 16'h0008, 32'h0008_0000, 1'b1);
        chk("single_ret", 32'(irq_ret_o), 32'h0008);
        chk("single_int_low", 32'(int_o), 32'd0);
        tick(1'b1, 16'h0000, 32'h0008_0000, 1'b0);
        chk("single_ret_once", 32'(irq_ret_o), 32'h0);

        // Masked source 5 never fires, then is enabled.
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 16'h0020, 32'h0, 1'b0);
            if (int_o) chk("mask_hold", 32'(int_o), 32'd0);
        end
        wait_int("mask_latency", 16'h0020, 32'h0020_0000);
        chk("mask_cause", mcause_o, 32'h8000_0015);
        tick(1'b1, 16'h0020, 32'h0020_0000, 1'b1);
        chk("mask_ret", 32'(irq_ret_o), 32'h0020);
        tick(1'b1, 16'h0000, 32'h0, 1'b0);

        // Committed request on source 7 survives withdrawal of line and enable.
        wait_int("commit_latency", 16'h0080, 32'h0080_0000);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 16'h0000, 32'h0, 1'b0);
            chk("commit_int", 32'(int_o), 32'd1);
            chk("commit_cause", mcause_o, 32'h8000_0017);
        end
        tick(1'b1, 16'h0000, 32'h0, 1'b1);
        chk("commit_ret", 32'(irq_ret_o), 32'h0080);
        tick(1'b1, 16'h0000, 32'h0, 1'b0);

        // Round-robin between sources 2 and 9; each drops only on its ack.
        pend = 16'h0204;
        for (int c = 0; c < 300 && svc_q.size() < 6; c++) begin
            tick(1'b1, pend, 32'h0204_0000, int_o);
            pend = 16'h0204 & ~irq_ret_o;
            for (int k = 0; k < N; k++) if (irq_ret_o[k]) svc_q.push_back(k);
        end
        chk("rr_count", 32'(svc_q.size()), 32'd6);
        for (int i = 1; i < svc_q.size(); i++) begin
            chk("rr_alternate", 32'(svc_q[i] != svc_q[i-1]), 32'd1);
            chk("rr_member",    32'(svc_q[i] == 2 || svc_q[i] == 9), 32'd1);
        end
        tick(1'b1, 16'h0, 32'h0, 1'b0);

        // Random traffic against the model: sticky peripheral lines cleared on
        // acknowledge, drifting mie, responsive and stray int_rst, rare resets.
        pend = '0;
        rmie = $urandom;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(7) == 0) rmie = $urandom;
            pend = pend | 16'($urandom & $urandom & $urandom);
            rrst = ($urandom_range(99) != 0);
            tick(rrst, pend,
                 rmie, int_o ? ($urandom_range(1) == 1) : ($urandom_range(9) == 0));
            pend = pend & ~irq_ret_o;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
